// File: rtl/div_ctrl.sv
// Radix-2 restoring divider with its execute-stage sequencing for MIPS DIV/DIVU.
// Produces one quotient bit per cycle and holds the pipeline until HI/LO are written.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall_div,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             neg_a;
  logic             neg_b;

  // One restoring step: diff can never exceed 2^WIDTH when non-negative, so
  // both top bits being clear is the "fits" test.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    diff     = {1'b0, rem_sh} - {2'b00, dvs};
    ge       = ~|diff[WIDTH+1:WIDTH];
    rem_next = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
    neg_a    = signed_div & a[WIDTH-1];
    neg_b    = signed_div & b[WIDTH-1];
  end

  always_comb begin
    stall_div = 1'b0;
    if (rst && !annul) begin
      case (state)
        IDLE:    stall_div = start;
        RUN:     stall_div = 1'b1;
        default: stall_div = 1'b0;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign ready = (state == DONE) && !annul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (annul) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            rem    <= '0;
            quo    <= cond_neg(a, neg_a);
            dvs    <= cond_neg(b, neg_b);
            cnt    <= '0;
            if (b == '0) begin
              lo    <= '1;
              hi    <= a;
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            lo    <= cond_neg(quo_next, sign_q);
            hi    <= cond_neg(rem_next, sign_r);
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
